// File: rtl/mem_stage_pkg.sv
// Shared types for the memory-access stage: WB select codes, FSM states and the
// MEM/WB register payload.
package mem_stage_pkg;

   localparam int unsigned PcWidth  = 32;
   localparam int unsigned CntWidth = 16;

   typedef enum logic [1:0] {
      WbSelAlu = 2'd0,
      WbSelMem = 2'd1,
      WbSelPc  = 2'd2,
      WbSelImm = 2'd3
   } wb_sel_e;

   typedef enum logic [0:0] {
      StIdle = 1'b0,
      StBusy = 1'b1
   } mem_state_e;

   typedef struct packed {
      logic               valid;
      logic               reg_we;
      logic               is_jump;
      logic               branch_taken;
      logic [1:0]         wb_sel;
      logic [4:0]         reg_dst;
      logic [31:0]        alu_res;
      logic [31:0]        mem_data;
      logic [31:0]        imm;
      logic [31:0]        jump_addr;
      logic [PcWidth-1:0] next_pc;
      logic [PcWidth-1:0] branch_addr;
   } wb_fields_t;

endpackage

// File: rtl/mem_stage_wb_reg.sv
// MEM/WB pipeline register. Loads a new instruction or inserts a bubble that
// clears the control bits while keeping the data fields.
module mem_stage_wb_reg
   import mem_stage_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       load_i,
   input  wb_fields_t fields_i,
   output wb_fields_t fields_o
);

   wb_fields_t fields_q, fields_d;

   always_comb begin
      fields_d = fields_q;
      if (load_i) begin
         fields_d = fields_i;
      end else begin
         fields_d.valid        = 1'b0;
         fields_d.reg_we       = 1'b0;
         fields_d.is_jump      = 1'b0;
         fields_d.branch_taken = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         fields_q <= '0;
      end else begin
         fields_q <= fields_d;
      end
   end

   assign fields_o = fields_q;

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: req/ack data-memory port with wait states and
// timeout, upstream stall, and the MEM/WB register feeding write-back.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int unsigned DmemAddrWidth = 16,
   parameter int unsigned TimeoutCycles = 255
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     in_valid_i,
   input  logic                     in_mem_read_i,
   input  logic                     in_mem_write_i,
   input  logic [31:0]              in_alu_res_i,
   input  logic [31:0]              in_store_data_i,
   input  logic                     in_reg_write_enable_i,
   input  logic                     in_is_jump_i,
   input  logic                     in_branch_taken_i,
   input  logic [1:0]               in_wb_res_mux_i,
   input  logic [4:0]               in_reg_dst_i,
   input  logic [31:0]              in_imm_i,
   input  logic [31:0]              in_jump_addr_i,
   input  logic [PcWidth-1:0]       in_next_pc_i,
   input  logic [PcWidth-1:0]       in_branch_addr_i,
   output logic                     dmem_req_o,
   output logic                     dmem_we_o,
   output logic [DmemAddrWidth-1:0] dmem_addr_o,
   output logic [31:0]              dmem_wdata_o,
   input  logic [31:0]              dmem_rdata_i,
   input  logic                     dmem_ack_i,
   output logic                     mem_stall_o,
   output logic                     mem_fault_o,
   output logic                     out_valid_o,
   output logic                     out_reg_write_enable_o,
   output logic                     out_is_jump_o,
   output logic                     out_branch_taken_o,
   output logic [1:0]               out_wb_res_mux_o,
   output logic [4:0]               out_reg_dst_o,
   output logic [31:0]              out_alu_res_o,
   output logic [31:0]              out_mem_data_o,
   output logic [31:0]              out_imm_o,
   output logic [31:0]              out_jump_addr_o,
   output logic [PcWidth-1:0]       out_next_pc_o,
   output logic [PcWidth-1:0]       out_branch_addr_o
);

   localparam logic [CntWidth-1:0] TimeoutCnt = CntWidth'(TimeoutCycles);

   mem_state_e          state_q;
   logic [CntWidth-1:0] cnt_q;
   logic                fault_q;

   logic       memop, is_read, st_idle, st_busy, timeout, ack_ok, load;
   wb_fields_t fields_d, fields_q;

   assign memop   = in_valid_i & (in_mem_read_i | in_mem_write_i);
   // Read and write together is an illegal encoding that behaves as a store.
   assign is_read = in_mem_read_i & ~in_mem_write_i;
   assign st_idle = (state_q == StIdle);
   assign st_busy = (state_q == StBusy);

   assign dmem_req_o   = rst_ni & ((st_idle & memop) | st_busy);
   assign dmem_we_o    = in_mem_write_i;
   assign dmem_addr_o  = in_alu_res_i[DmemAddrWidth-1:0];
   assign dmem_wdata_o = in_store_data_i;

   assign ack_ok      = dmem_req_o & dmem_ack_i;
   assign timeout     = st_busy & ~dmem_ack_i & (cnt_q == TimeoutCnt);
   assign mem_stall_o = dmem_req_o & ~dmem_ack_i & ~timeout;
   assign load        = (st_idle & ~memop) | ack_ok | timeout;

   always_comb begin
      fields_d              = '0;
      fields_d.valid        = in_valid_i | timeout;
      fields_d.reg_we       = in_reg_write_enable_i & ~timeout;
      fields_d.is_jump      = in_is_jump_i;
      fields_d.branch_taken = in_branch_taken_i;
      fields_d.wb_sel       = in_wb_res_mux_i;
      fields_d.reg_dst      = in_reg_dst_i;
      fields_d.alu_res      = in_alu_res_i;
      fields_d.mem_data     = (ack_ok && is_read) ? dmem_rdata_i : 32'h0;
      fields_d.imm          = in_imm_i;
      fields_d.jump_addr    = in_jump_addr_i;
      fields_d.next_pc      = in_next_pc_i;
      fields_d.branch_addr  = in_branch_addr_i;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         fault_q <= 1'b0;
      end else begin
         fault_q <= timeout;
         unique case (state_q)
            StIdle: begin
               if (memop && !dmem_ack_i) begin
                  state_q <= StBusy;
                  cnt_q   <= CntWidth'(1);
               end
            end
            StBusy: begin
               if (dmem_ack_i || timeout) begin
                  state_q <= StIdle;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + CntWidth'(1);
               end
            end
            default: begin
               state_q <= StIdle;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   mem_stage_wb_reg u_wb_reg (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .load_i   (load),
      .fields_i (fields_d),
      .fields_o (fields_q)
   );

   assign mem_fault_o            = fault_q;
   assign out_valid_o            = fields_q.valid;
   assign out_reg_write_enable_o = fields_q.reg_we;
   assign out_is_jump_o          = fields_q.is_jump;
   assign out_branch_taken_o     = fields_q.branch_taken;
   assign out_wb_res_mux_o       = fields_q.wb_sel;
   assign out_reg_dst_o          = fields_q.reg_dst;
   assign out_alu_res_o          = fields_q.alu_res;
   assign out_mem_data_o         = fields_q.mem_data;
   assign out_imm_o              = fields_q.imm;
   assign out_jump_addr_o        = fields_q.jump_addr;
   assign out_next_pc_o          = fields_q.next_pc;
   assign out_branch_addr_o      = fields_q.branch_addr;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: single-cycle vector table plus wait-state,
// timeout, reset-in-busy and branch-load sequences.
module tb_mem_stage;
   import mem_stage_pkg::*;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               in_valid, in_rd, in_wr, in_we, in_jump, in_br;
   logic [31:0]        in_alu, in_sdata, in_imm, in_jaddr;
   logic [1:0]         in_wbsel;
   logic [4:0]         in_dst;
   logic [PcWidth-1:0] in_npc, in_baddr;
   logic               dmem_req, dmem_we, dmem_ack;
   logic [15:0]        dmem_addr;
   logic [31:0]        dmem_wdata, dmem_rdata;
   logic               mem_stall, mem_fault;
   logic               out_valid, out_we, out_jump, out_br;
   logic [1:0]         out_wbsel;
   logic [4:0]         out_dst;
   logic [31:0]        out_alu, out_mdata, out_imm, out_jaddr;
   logic [PcWidth-1:0] out_npc, out_baddr;

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   mem_stage #(
      .DmemAddrWidth (16),
      .TimeoutCycles (4)
   ) dut (
      .clk_i                  (clk),
      .rst_ni                 (rst_n),
      .in_valid_i             (in_valid),
      .in_mem_read_i          (in_rd),
      .in_mem_write_i         (in_wr),
      .in_alu_res_i           (in_alu),
      .in_store_data_i        (in_sdata),
      .in_reg_write_enable_i  (in_we),
      .in_is_jump_i           (in_jump),
      .in_branch_taken_i      (in_br),
      .in_wb_res_mux_i        (in_wbsel),
      .in_reg_dst_i           (in_dst),
      .in_imm_i               (in_imm),
      .in_jump_addr_i         (in_jaddr),
      .in_next_pc_i           (in_npc),
      .in_branch_addr_i       (in_baddr),
      .dmem_req_o             (dmem_req),
      .dmem_we_o              (dmem_we),
      .dmem_addr_o            (dmem_addr),
      .dmem_wdata_o           (dmem_wdata),
      .dmem_rdata_i           (dmem_rdata),
      .dmem_ack_i             (dmem_ack),
      .mem_stall_o            (mem_stall),
      .mem_fault_o            (mem_fault),
      .out_valid_o            (out_valid),
      .out_reg_write_enable_o (out_we),
      .out_is_jump_o          (out_jump),
      .out_branch_taken_o     (out_br),
      .out_wb_res_mux_o       (out_wbsel),
      .out_reg_dst_o          (out_dst),
      .out_alu_res_o          (out_alu),
      .out_mem_data_o         (out_mdata),
      .out_imm_o              (out_imm),
      .out_jump_addr_o        (out_jaddr),
      .out_next_pc_o          (out_npc),
      .out_branch_addr_o      (out_baddr)
   );

   typedef struct {
      logic        valid, rd, wr, we, jump, br, ack;
      logic [1:0]  wbsel;
      logic [4:0]  dst;
      logic [31:0] alu, sdata, rdata;
      logic        e_req, e_valid;
      logic [31:0] e_mdata;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      in_valid = 0; in_rd = 0; in_wr = 0; in_we = 0; in_jump = 0; in_br = 0;
      in_alu = '0; in_sdata = '0; in_imm = '0; in_jaddr = '0; in_wbsel = '0;
      in_dst = '0; in_npc = '0; in_baddr = '0; dmem_ack = 0; dmem_rdata = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      //          valid rd wr we jmp br ack wbsel      dst   alu           sdata         rdata         req val mdata
      vecs[0] = '{1'b1, 0, 0, 1, 0, 0, 0, 2'(WbSelAlu), 5'd5, 32'h0000_1234, 32'h0, 32'h0, 0, 1, 32'h0};
      vecs[1] = '{1'b1, 1, 0, 1, 0, 0, 1, 2'(WbSelMem), 5'd7, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1, 1, 32'hDEAD_BEEF};
      vecs[2] = '{1'b1, 0, 1, 0, 0, 0, 1, 2'(WbSelAlu), 5'd0, 32'h0000_0020, 32'hCAFE_F00D, 32'h55, 1, 1, 32'h0};
      vecs[3] = '{1'b0, 1, 0, 0, 0, 0, 0, 2'(WbSelMem), 5'd3, 32'h0000_0030, 32'h0, 32'h0, 0, 0, 32'h0};
      vecs[4] = '{1'b1, 1, 1, 0, 0, 0, 1, 2'(WbSelAlu), 5'd0, 32'h0001_0044, 32'h1111_2222, 32'h77, 1, 1, 32'h0};
      vecs[5] = '{1'b1, 0, 0, 1, 1, 0, 0, 2'(WbSelPc),  5'd1, 32'h0000_0050, 32'h0, 32'h0, 0, 1, 32'h0};
      vecs[6] = '{1'b1, 0, 0, 1, 0, 0, 1, 2'(WbSelImm), 5'd9, 32'h0000_0060, 32'h0, 32'h99, 0, 1, 32'h0};
      vecs[7] = '{1'b1, 0, 0, 0, 0, 1, 0, 2'(WbSelAlu), 5'd0, 32'h0000_0070, 32'h0, 32'h0, 0, 1, 32'h0};

      // Reset with a pending load: no request may escape, outputs stay zero.
      idle_inputs();
      rst_n = 0; in_valid = 1; in_rd = 1;
      #1 chk("reset_req", 32'(dmem_req), 32'h0);
      tick(); tick();
      chk("reset_valid", 32'(out_valid), 32'h0);
      chk("reset_fault", 32'(mem_fault), 32'h0);
      chk("reset_alu", out_alu, 32'h0);
      chk("reset_npc", out_npc, 32'h0);
      @(negedge clk);
      rst_n = 1;
      idle_inputs();

      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         in_valid = vecs[i].valid; in_rd = vecs[i].rd; in_wr = vecs[i].wr;
         in_we = vecs[i].we; in_jump = vecs[i].jump; in_br = vecs[i].br;
         dmem_ack = vecs[i].ack; in_wbsel = vecs[i].wbsel; in_dst = vecs[i].dst;
         in_alu = vecs[i].alu; in_sdata = vecs[i].sdata; dmem_rdata = vecs[i].rdata;
         in_imm = vecs[i].alu ^ 32'hFFFF_0000; in_npc = vecs[i].alu + 32'd4;
         in_jaddr = vecs[i].alu + 32'd8; in_baddr = vecs[i].alu + 32'd12;
         #1;
         chk($sformatf("v%0d_req", i), 32'(dmem_req), 32'(vecs[i].e_req));
         chk($sformatf("v%0d_stall", i), 32'(mem_stall), 32'h0);
         if (vecs[i].e_req) begin
            chk($sformatf("v%0d_we", i), 32'(dmem_we), 32'(vecs[i].wr));
            chk($sformatf("v%0d_addr", i), 32'(dmem_addr), 32'(vecs[i].alu[15:0]));
            chk($sformatf("v%0d_wdata", i), dmem_wdata, vecs[i].sdata);
         end
         tick();
         chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'(vecs[i].e_valid));
         chk($sformatf("v%0d_rwe", i), 32'(out_we), 32'(vecs[i].we));
         chk($sformatf("v%0d_jump", i), 32'(out_jump), 32'(vecs[i].jump));
         chk($sformatf("v%0d_br", i), 32'(out_br), 32'(vecs[i].br));
         chk($sformatf("v%0d_wbsel", i), 32'(out_wbsel), 32'(vecs[i].wbsel));
         chk($sformatf("v%0d_dst", i), 32'(out_dst), 32'(vecs[i].dst));
         chk($sformatf("v%0d_alu", i), out_alu, vecs[i].alu);
         chk($sformatf("v%0d_mdata", i), out_mdata, vecs[i].e_mdata);
         chk($sformatf("v%0d_imm", i), out_imm, vecs[i].alu ^ 32'hFFFF_0000);
         chk($sformatf("v%0d_npc", i), out_npc, vecs[i].alu + 32'd4);
         chk($sformatf("v%0d_jaddr", i), out_jaddr, vecs[i].alu + 32'd8);
         chk($sformatf("v%0d_baddr", i), out_baddr, vecs[i].alu + 32'd12);
      end

      // Store acked after three wait cycles.
      @(negedge clk);
      idle_inputs();
      in_valid = 1; in_wr = 1; in_we = 0; in_alu = 32'h80; in_sdata = 32'hA5A5_5A5A;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("st_stall%0d", i), 32'(mem_stall), 32'h1);
         chk($sformatf("st_we%0d", i), 32'(dmem_we), 32'h1);
         tick();
         chk($sformatf("st_bubble%0d", i), 32'(out_valid), 32'h0);
         @(negedge clk);
      end
      dmem_ack = 1;
      #1;
      chk("st_ack_stall", 32'(mem_stall), 32'h0);
      chk("st_ack_req", 32'(dmem_req), 32'h1);
      tick();
      chk("st_done_valid", 32'(out_valid), 32'h1);
      chk("st_done_alu", out_alu, 32'h80);
      chk("st_done_mdata", out_mdata, 32'h0);

      // Load never acked: timeout after four busy cycles.
      @(negedge clk);
      idle_inputs();
      in_valid = 1; in_rd = 1; in_we = 1; in_wbsel = 2'(WbSelMem); in_alu = 32'h90;
      in_jump = 1; in_jaddr = 32'h300;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk($sformatf("to_stall%0d", i), 32'(mem_stall), 32'h1);
         tick();
         chk($sformatf("to_fault%0d", i), 32'(mem_fault), 32'h0);
         chk($sformatf("to_bubble%0d", i), 32'(out_valid), 32'h0);
         chk($sformatf("to_jump_bubble%0d", i), 32'(out_jump), 32'h0);
         @(negedge clk);
      end
      #1;
      chk("to_last_stall", 32'(mem_stall), 32'h0);
      chk("to_last_req", 32'(dmem_req), 32'h1);
      tick();
      chk("to_fault", 32'(mem_fault), 32'h1);
      chk("to_valid", 32'(out_valid), 32'h1);
      chk("to_rwe", 32'(out_we), 32'h0);
      chk("to_mdata", out_mdata, 32'h0);
      chk("to_jump", 32'(out_jump), 32'h1);
      chk("to_jaddr", out_jaddr, 32'h300);
      @(negedge clk);
      idle_inputs();
      #1 chk("to_req_drop", 32'(dmem_req), 32'h0);
      tick();
      chk("to_fault_pulse", 32'(mem_fault), 32'h0);

      // Reset asserted while busy.
      @(negedge clk);
      in_valid = 1; in_rd = 1; in_alu = 32'hB0; in_we = 1;
      tick();
      chk("rb_busy_bubble", 32'(out_valid), 32'h0);
      @(negedge clk);
      rst_n = 0;
      #1 chk("rb_req_low", 32'(dmem_req), 32'h0);
      tick();
      chk("rb_valid", 32'(out_valid), 32'h0);
      chk("rb_alu", out_alu, 32'h0);
      chk("rb_fault", 32'(mem_fault), 32'h0);
      @(negedge clk);
      rst_n = 1;
      idle_inputs();
      #1 chk("rb_idle_req", 32'(dmem_req), 32'h0);
      tick();
      chk("rb_fault_after", 32'(mem_fault), 32'h0);

      // Branch-taken load with one wait cycle.
      @(negedge clk);
      in_valid = 1; in_rd = 1; in_we = 1; in_br = 1; in_baddr = 32'h40;
      in_alu = 32'hA0; in_wbsel = 2'(WbSelMem); dmem_rdata = 32'h1234_5678;
      tick();
      chk("br_bubble", 32'(out_br), 32'h0);
      chk("br_bubble_valid", 32'(out_valid), 32'h0);
      @(negedge clk);
      dmem_ack = 1;
      tick();
      chk("br_taken", 32'(out_br), 32'h1);
      chk("br_addr", out_baddr, 32'h40);
      chk("br_mdata", out_mdata, 32'h1234_5678);
      chk("br_wbsel", 32'(out_wbsel), 32'(WbSelMem));
      @(negedge clk);
      idle_inputs();
      tick();
      chk("br_after", 32'(out_br), 32'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
